// File: rtl/alu_add_and_cmp.sv
// Registered ADD/AND/CMP ALU slice with NZCV flag generation and one-cycle latency.
// Optional feature: define ALU_ADD_SATURATE_EN to make ADD saturate on signed overflow.
module alu_add_and_cmp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [3:0]       flag_in,
   input  logic             s,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       new_flag,
   output logic             valid_out,
   output logic             wr_en
);

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_AND  = 2'b01,
      OP_CMP  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   localparam int MSB = WIDTH - 1;

   op_e              op_sel;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             add_ovf;
   logic             cmp_ovf;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] and_res;
   logic [WIDTH-1:0] result_nxt;
   logic [3:0]       flag_nxt;
   logic             wr_nxt;

   assign op_sel = op_e'(op);

   // Both arithmetic paths are one bit wider so carry / borrow fall out of the top bit.
   always_comb begin
      sum     = {1'b0, in1} + {1'b0, in2};
      diff    = {1'b0, in1} - {1'b0, in2};
      add_ovf = (in1[MSB] == in2[MSB]) && (sum[MSB] != in1[MSB]);
      cmp_ovf = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]);
      and_res = in1 & in2;
`ifdef ALU_ADD_SATURATE_EN
      if (add_ovf) begin
         add_res = in1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         add_res = sum[WIDTH-1:0];
      end
`else
      add_res = sum[WIDTH-1:0];
`endif
   end

   always_comb begin
      result_nxt = result;
      flag_nxt   = flag_in;
      wr_nxt     = 1'b0;
      case (op_sel)
         OP_ADD: begin
            result_nxt = add_res;
            wr_nxt     = 1'b1;
            if (s) begin
               flag_nxt = {add_res[MSB], (add_res == '0), sum[WIDTH], add_ovf};
            end
         end
         OP_AND: begin
            result_nxt = and_res;
            wr_nxt     = 1'b1;
            if (s) begin
               flag_nxt = {and_res[MSB], (and_res == '0), flag_in[1:0]};
            end
         end
         // CMP always writes flags; carry means "no borrow".
         OP_CMP: begin
            flag_nxt = {diff[MSB], (diff[WIDTH-1:0] == '0), ~diff[WIDTH], cmp_ovf};
         end
         default: begin
            flag_nxt = flag_in;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         new_flag  <= 4'b0000;
         valid_out <= 1'b0;
         wr_en     <= 1'b0;
      end else begin
         valid_out <= valid_in;
         wr_en     <= valid_in & wr_nxt;
         if (valid_in) begin
            result   <= result_nxt;
            new_flag <= flag_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_add_and_cmp.sv
// Self-checking bench for alu_add_and_cmp: directed cases plus randomized traffic
// compared against an arithmetic reference model (honours ALU_ADD_SATURATE_EN).
module tb_alu_add_and_cmp;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [1:0]  op;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [3:0]  flag_in;
   logic        s;
   logic [31:0] result;
   logic [3:0]  new_flag;
   logic        valid_out;
   logic        wr_en;

   int compared;
   int mismatched;

   alu_add_and_cmp #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .valid_in(valid_in),
      .op(op),
      .in1(in1),
      .in2(in2),
      .flag_in(flag_in),
      .s(s),
      .result(result),
      .new_flag(new_flag),
      .valid_out(valid_out),
      .wr_en(wr_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: signed/unsigned arithmetic on 64-bit integers.
   task automatic model_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] fin, input logic sf, input logic [31:0] prev,
                           output logic [31:0] res, output logic [3:0] fl, output logic wr);
      longint ss;
      longint us;
      logic   ovf;
      logic   cy;
      logic [31:0] w;
      res = prev;
      fl  = fin;
      wr  = 1'b0;
      case (mop)
         2'b00: begin
            ss  = longint'($signed(a)) + longint'($signed(b));
            us  = longint'(a) + longint'(b);
            ovf = (ss > SMAX) || (ss < SMIN);
            cy  = (us > 64'sh0000_0000_FFFF_FFFF);
            w   = us[31:0];
`ifdef ALU_ADD_SATURATE_EN
            if (ovf) w = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            res = w;
            wr  = 1'b1;
            if (sf) fl = {w[31], (w == 32'd0), cy, ovf};
         end
         2'b01: begin
            w   = a & b;
            res = w;
            wr  = 1'b1;
            if (sf) fl = {w[31], (w == 32'd0), fin[1], fin[0]};
         end
         2'b10: begin
            ss  = longint'($signed(a)) - longint'($signed(b));
            w   = a - b;
            ovf = (ss > SMAX) || (ss < SMIN);
            fl  = {w[31], (a == b), (a >= b), ovf};
         end
         default: begin
            fl = fin;
         end
      endcase
   endtask

   task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] f, input logic sf);
      valid_in = v;
      op       = o;
      in1      = a;
      in2      = b;
      flag_in  = f;
      s        = sf;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 2'b00, 32'd5, 32'd3, 4'b1111, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_result: got %h expected %h", result, 32'd0);
      end
      compared++;
      if (new_flag !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_flag: got %b expected %b", new_flag, 4'b0000);
      end
      compared++;
      if (valid_out !== 1'b0 || wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_valid_wr: got %b%b expected 00", valid_out, wr_en);
      end
      reset = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
   endtask

   task automatic test_add;
      logic [31:0] exp_r;
      logic [3:0]  exp_f;
`ifdef ALU_ADD_SATURATE_EN
      exp_r = 32'h7FFF_FFFF;
      exp_f = 4'b0001;
`else
      exp_r = 32'h8000_0000;
      exp_f = 4'b1001;
`endif
      drive(1'b1, 2'b00, 32'h7FFF_FFFF, 32'd1, 4'b0000, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== exp_r || new_flag !== exp_f) begin
         mismatched++;
         $display("[TB] FAIL add_overflow: got %h/%b expected %h/%b", result, new_flag, exp_r, exp_f);
      end
      compared++;
      if (valid_out !== 1'b1 || wr_en !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL add_valid_wr: got %b%b expected 11", valid_out, wr_en);
      end
      drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== 32'd0 || new_flag !== 4'b0110) begin
         mismatched++;
         $display("[TB] FAIL add_carry: got %h/%b expected %h/%b", result, new_flag, 32'd0, 4'b0110);
      end
      drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1, 4'b1010, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'd0 || new_flag !== 4'b1010) begin
         mismatched++;
         $display("[TB] FAIL add_no_s: got %h/%b expected %h/%b", result, new_flag, 32'd0, 4'b1010);
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
   endtask

   task automatic test_and;
      drive(1'b1, 2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b0011, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== 32'd0 || new_flag !== 4'b0111 || wr_en !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL and_flags: got %h/%b/%b expected %h/%b/1", result, new_flag, wr_en, 32'd0, 4'b0111);
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
   endtask

   task automatic test_cmp;
      drive(1'b1, 2'b00, 32'h10, 32'h2, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'h12) begin
         mismatched++;
         $display("[TB] FAIL cmp_setup: got %h expected %h", result, 32'h12);
      end
      drive(1'b1, 2'b10, 32'd3, 32'd5, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'h12 || new_flag !== 4'b1000 || wr_en !== 1'b0 || valid_out !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL cmp_less: got %h/%b/wr%b/v%b expected %h/%b/wr0/v1", result, new_flag, wr_en, valid_out, 32'h12, 4'b1000);
      end
      drive(1'b1, 2'b10, 32'd5, 32'd5, 4'b0000, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== 32'h12 || new_flag !== 4'b0110) begin
         mismatched++;
         $display("[TB] FAIL cmp_equal: got %h/%b expected %h/%b", result, new_flag, 32'h12, 4'b0110);
      end
      drive(1'b1, 2'b11, 32'd7, 32'd9, 4'b1101, 1'b1);
      @(negedge clk);
      compared++;
      if (result !== 32'h12 || new_flag !== 4'b1101 || wr_en !== 1'b0 || valid_out !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL reserved_op: got %h/%b/wr%b/v%b expected %h/%b/wr0/v1", result, new_flag, wr_en, valid_out, 32'h12, 4'b1101);
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'h12 || new_flag !== 4'b1101 || valid_out !== 1'b0 || wr_en !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL idle_hold: got %h/%b/v%b/wr%b expected %h/%b/v0/wr0", result, new_flag, valid_out, wr_en, 32'h12, 4'b1101);
      end
   endtask

   task automatic test_back_to_back;
      drive(1'b1, 2'b00, 32'd2, 32'd2, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'd4 || valid_out !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL b2b_first: got %h/v%b expected %h/v1", result, valid_out, 32'd4);
      end
      drive(1'b1, 2'b01, 32'd6, 32'd3, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (result !== 32'd2 || valid_out !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL b2b_second: got %h/v%b expected %h/v1", result, valid_out, 32'd2);
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
      @(negedge clk);
      compared++;
      if (valid_out !== 1'b0 || result !== 32'd2) begin
         mismatched++;
         $display("[TB] FAIL b2b_drop: got %h/v%b expected %h/v0", result, valid_out, 32'd2);
      end
   endtask

   task automatic test_random;
      logic [31:0] m_res;
      logic [3:0]  m_flag;
      logic        m_valid;
      logic        m_wr;
      logic [31:0] r_res;
      logic [3:0]  r_flag;
      logic        r_wr;
      logic [31:0] a;
      logic [31:0] b;
      m_res   = result;
      m_flag  = new_flag;
      m_valid = valid_out;
      m_wr    = wr_en;
      for (int i = 0; i < 400; i++) begin
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 5))
            0: a = 32'h7FFF_FFFF;
            1: b = 32'h8000_0000;
            2: b = a;
            3: a = 32'hFFFF_FFFF;
            default: ;
         endcase
         reset = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (reset) begin
            m_res   = 32'd0;
            m_flag  = 4'b0000;
            m_valid = 1'b0;
            m_wr    = 1'b0;
         end else begin
            model_op(op, in1, in2, flag_in, s, m_res, r_res, r_flag, r_wr);
            m_valid = valid_in;
            m_wr    = valid_in & r_wr;
            if (valid_in) begin
               m_res  = r_res;
               m_flag = r_flag;
            end
         end
         @(negedge clk);
         compared++;
         if (result !== m_res || new_flag !== m_flag || valid_out !== m_valid || wr_en !== m_wr) begin
            mismatched++;
            $display("[TB] FAIL random[%0d]: got %h/%b/v%b/wr%b expected %h/%b/v%b/wr%b",
                     i, result, new_flag, valid_out, wr_en, m_res, m_flag, m_valid, m_wr);
         end
      end
      reset = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      drive(1'b0, 2'b00, 32'd0, 32'd0, 4'b0000, 1'b0);
      test_reset();
      test_add();
      test_and();
      test_cmp();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_add_and_cmp.md
Name: alu_add_and_cmp

Overview:
- Registered ALU slice for the ADD (opcode 0000), AND (0100) and CMP (1011) operations of the processor datapath.
- The decoder selects the operation; the slice computes the result and the optional NZCV flag update.
- Outputs are registered with one-cycle latency, for the execute stage's writeback and flag register.

Parameters:
- WIDTH, 32, operand/result width in bits; flag semantics use bit WIDTH-1 as sign.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  operation request this cycle
- op  input  2  00=ADD, 01=AND, 10=CMP, 11=reserved
- in1  input  WIDTH  first operand (signed two's complement)
- in2  input  WIDTH  second operand (signed two's complement)
- flag_in  input  4  current flags {N,Z,C,V} (bit3=N, bit2=Z, bit1=C, bit0=V)
- s  input  1  set-flags enable for ADD/AND; ignored for CMP
- result  output  WIDTH  registered result
- new_flag  output  4  registered updated flags {N,Z,C,V}
- valid_out  output  1  result/new_flag valid, one cycle after valid_in
- wr_en  output  1  result should be written back (ADD/AND only)

Behaviour:
- Reset (sync, high, on clk edge):
  - result=0, new_flag=0000, valid_out=0, wr_en=0.
  - Reset dominates valid_in in the same cycle; an operation in flight is discarded.
- Latency: registers update on every clk edge where valid_in=1.
  - valid_out is high exactly one cycle after valid_in was high, otherwise low.
  - When valid_in=0, result and new_flag hold their previous values.
- ADD:
  - sum = in1+in2, computed WIDTH+1 bits wide; result = sum[WIDTH-1:0]; wr_en=1.
  - Flags when s=1: N=result[MSB]; Z=(result==0); C=carry out (sum[WIDTH]); V=(in1[MSB]==in2[MSB]) && (result[MSB]!=in1[MSB]).
  - When s=0: new_flag=flag_in.
- AND:
  - result = in1 & in2; wr_en=1.
  - Flags when s=1: N=result[MSB]; Z=(result==0); C and V copied from flag_in.
  - When s=0: new_flag=flag_in.
- CMP:
  - diff = in1-in2; flags are always updated regardless of s.
  - N=diff[MSB]; Z=(diff==0); C=1 when no borrow (in1>=in2 unsigned); V=(in1[MSB]!=in2[MSB]) && (diff[MSB]!=in1[MSB]).
  - result register holds its previous value; wr_en=0.
- Reserved op 11: result holds, new_flag=flag_in, wr_en=0, valid_out still asserted.
- Wrap-around: ADD and CMP wrap modulo 2^WIDTH; no exceptions raised.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_ADD_SATURATE_EN.
- Defined:
  - ADD result saturates on signed overflow: 0x7FFFFFFF for positive overflow, 0x80000000 for negative overflow (for WIDTH=32).
  - V and C are still computed from the unsaturated sum; N and Z come from the saturated result.
- Undefined: ADD wraps as described above.
- AND and CMP are unaffected either way.

Test Plan:
- Reset: assert reset with valid_in=1, op=ADD, in1=5, in2=3 -> next cycle result=0, new_flag=0000, valid_out=0, wr_en=0.
- ADD with s=1: in1=0x7FFFFFFF, in2=1 -> one cycle later:
  - macro off: result=0x80000000, flags N=1 Z=0 C=0 V=1 (1001).
  - macro on: result=0x7FFFFFFF, flags N=0 Z=0 C=0 V=1.
- ADD carry with s=1: in1=0xFFFFFFFF, in2=1 -> result=0, flags 0110; repeat with s=0 and flag_in=1010 -> result=0, new_flag=1010.
- AND with s=1: flag_in=0011, in1=0xF0F0F0F0, in2=0x0F0F0F0F -> result=0, new_flag=0111 (C,V preserved).
- CMP with s=0 (ignored): previous result=0x12, in1=3, in2=5 -> new_flag=1000, result stays 0x12, wr_en=0; in1=5, in2=5 -> new_flag=0110.
- Back-to-back: ADD(2,2) then AND(6,3) on consecutive cycles -> results 4 then 2 on consecutive cycles; valid_out high for two cycles, then low once valid_in drops.
